// File: rtl/clock_unit_pkg.sv
// Shared types and helpers for the clock-enable / reset-sequencing unit.
package clock_unit_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } fsm_state_e;

  localparam int unsigned LOCK_SYNC_STAGES = 2;
  localparam int unsigned CFG_CALC_W       = 32;

  // A divide ratio of zero behaves as divide-by-one.
  function automatic logic [CFG_CALC_W-1:0] sanitise_div(input logic [CFG_CALC_W-1:0] div);
    return (div == '0) ? CFG_CALC_W'(1) : div;
  endfunction

  // Phase must land inside the period, so out-of-range values pin to the last slot.
  function automatic logic [CFG_CALC_W-1:0] sanitise_phase(input logic [CFG_CALC_W-1:0] div_s,
                                                           input logic [CFG_CALC_W-1:0] phase);
    return (phase >= div_s) ? (div_s - CFG_CALC_W'(1)) : phase;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One programmable-ratio, programmable-phase enable strobe with glitch-free config update.
module clock_divider_channel
  import clock_unit_pkg::*;
#(
  parameter int unsigned NB_DIV = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_in_reset,
  input  logic              i_hold,
  input  logic              i_cfg_we,
  input  logic [NB_DIV-1:0] i_cfg_div,
  input  logic [NB_DIV-1:0] i_cfg_phase,
  output logic              o_enable,
  output logic              o_pending_c
);

  logic [NB_DIV-1:0] cnt_q, cnt_d;
  logic [NB_DIV-1:0] div_q, div_d;
  logic [NB_DIV-1:0] phase_q, phase_d;
  logic [NB_DIV-1:0] sdiv_q, sdiv_d;
  logic [NB_DIV-1:0] sphase_q, sphase_d;
  logic              pending_q, pending_d;
  logic              enable_q, enable_d;
  logic              wrap;
  logic              apply;

  // i_hold is the channel reset for the coming cycle, so the strobe register lines up with it.
  always_comb begin
    div_d     = div_q;
    phase_d   = phase_q;
    sdiv_d    = sdiv_q;
    sphase_d  = sphase_q;
    pending_d = pending_q;
    wrap      = (cnt_q == (div_q - NB_DIV'(1)));
    apply     = pending_q && (i_in_reset || wrap);

    if (apply) begin
      div_d     = sdiv_q;
      phase_d   = sphase_q;
      pending_d = 1'b0;
    end
    if (i_cfg_we) begin
      sdiv_d    = NB_DIV'(sanitise_div(CFG_CALC_W'(i_cfg_div)));
      sphase_d  = NB_DIV'(sanitise_phase(sanitise_div(CFG_CALC_W'(i_cfg_div)),
                                         CFG_CALC_W'(i_cfg_phase)));
      pending_d = 1'b1;
    end

    if (i_in_reset || i_hold || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + NB_DIV'(1);
    end
    enable_d = !i_hold && (cnt_d == phase_d);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      div_q     <= NB_DIV'(1);
      phase_q   <= '0;
      sdiv_q    <= NB_DIV'(1);
      sphase_q  <= '0;
      pending_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      sdiv_q    <= sdiv_d;
      sphase_q  <= sphase_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
    end
  end

  assign o_enable    = enable_q;
  assign o_pending_c = pending_d;

endmodule

// File: rtl/clock_enable_unit.sv
// Lock qualification, staggered channel reset release and per-channel enable strobes.
module clock_enable_unit
  import clock_unit_pkg::*;
#(
  parameter  int unsigned NB_CHANNELS   = 3,
  parameter  int unsigned NB_DIV        = 8,
  parameter  int unsigned LOCK_CYCLES   = 1024,
  parameter  int unsigned RESET_STAGGER = 16,
  localparam int unsigned CH_W          = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_locked,
  input  logic                   i_cfg_valid,
  input  logic [CH_W-1:0]        i_cfg_channel,
  input  logic [NB_DIV-1:0]      i_cfg_div,
  input  logic [NB_DIV-1:0]      i_cfg_phase,
  output logic                   o_cfg_ready,
  output logic [NB_CHANNELS-1:0] o_enable,
  output logic [NB_CHANNELS-1:0] o_channel_reset,
  output logic                   o_valid
);

  localparam int unsigned QCNT_W = $clog2(LOCK_CYCLES);
  localparam int unsigned STAG_W = (RESET_STAGGER > 1) ? $clog2(RESET_STAGGER) : 1;

  logic [LOCK_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                        lock_s;
  fsm_state_e                  state_q, state_d;
  logic [QCNT_W-1:0]           qcnt_q, qcnt_d;
  logic [STAG_W-1:0]           stag_q, stag_d;
  logic [CH_W-1:0]             rel_idx_q, rel_idx_d;
  logic [NB_CHANNELS-1:0]      chan_rst_q, chan_rst_d;
  logic [NB_CHANNELS-1:0]      cfg_we_c, pending_c;
  logic                        valid_q, valid_d;
  logic                        cfg_ready_q, cfg_ready_d;

  always_comb begin
    sync_d = {sync_q[LOCK_SYNC_STAGES-2:0], i_locked};
    lock_s = sync_q[LOCK_SYNC_STAGES-1];
  end

  // Sequencer; losing lock anywhere overrides the per-state decision.
  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    stag_d     = stag_q;
    rel_idx_d  = rel_idx_q;
    chan_rst_d = chan_rst_q;
    valid_d    = valid_q;

    case (state_q)
      WAIT_LOCK: begin
        qcnt_d = '0;
        if (lock_s) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (qcnt_q == QCNT_W'(LOCK_CYCLES - 1)) begin
          state_d       = RELEASE;
          chan_rst_d[0] = 1'b0;
          rel_idx_d     = CH_W'(1);
          stag_d        = '0;
          if (NB_CHANNELS == 1) begin
            state_d = RUN;
            valid_d = 1'b1;
          end
        end else begin
          qcnt_d = qcnt_q + QCNT_W'(1);
        end
      end
      RELEASE: begin
        if (stag_q == STAG_W'(RESET_STAGGER - 1)) begin
          stag_d                = '0;
          chan_rst_d[rel_idx_q] = 1'b0;
          rel_idx_d             = rel_idx_q + CH_W'(1);
          if (rel_idx_q == CH_W'(NB_CHANNELS - 1)) begin
            state_d = RUN;
            valid_d = 1'b1;
          end
        end else begin
          stag_d = stag_q + STAG_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = WAIT_LOCK;
    endcase

    if (!lock_s) begin
      state_d    = WAIT_LOCK;
      qcnt_d     = '0;
      chan_rst_d = '1;
      valid_d    = 1'b0;
    end
  end

  // Out-of-range channel writes are acknowledged but touch nothing.
  always_comb begin
    cfg_we_c = '0;
    if (i_cfg_valid && cfg_ready_q && (32'(i_cfg_channel) < NB_CHANNELS)) begin
      cfg_we_c[i_cfg_channel] = 1'b1;
    end
    cfg_ready_d = ~|pending_c;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q      <= '0;
      state_q     <= WAIT_LOCK;
      qcnt_q      <= '0;
      stag_q      <= '0;
      rel_idx_q   <= '0;
      chan_rst_q  <= '1;
      valid_q     <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      stag_q      <= stag_d;
      rel_idx_q   <= rel_idx_d;
      chan_rst_q  <= chan_rst_d;
      valid_q     <= valid_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  for (genvar k = 0; k < NB_CHANNELS; k++) begin : g_chan
    clock_divider_channel #(
      .NB_DIV(NB_DIV)
    ) u_chan (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_in_reset (chan_rst_q[k]),
      .i_hold     (chan_rst_d[k]),
      .i_cfg_we   (cfg_we_c[k]),
      .i_cfg_div  (i_cfg_div),
      .i_cfg_phase(i_cfg_phase),
      .o_enable   (o_enable[k]),
      .o_pending_c(pending_c[k])
    );
  end

  assign o_channel_reset = chan_rst_q;
  assign o_valid         = valid_q;
  assign o_cfg_ready     = cfg_ready_q;

endmodule
